nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Digit-serial wide adder built around one brent_kung_adder_4b instance. It accepts WIDTH-bit operands through a valid/ready handshake and feeds the 4-bit adder one nibble per cycle, LSB nibble first, with a registered carry. It assembles the WIDTH-bit sum and final carry and presents them through a valid/ready output handshake. Used where area matters more than latency, e.g. address and accumulator updates in multi-cycle datapaths.

Parameters:
WIDTH, 32, operand/sum width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
valid_i  input  1  operand request valid
ready_o  output  1  block can accept operands
op1_i  input  WIDTH  operand 1, sampled on accept
op2_i  input  WIDTH  operand 2, sampled on accept
carry_i  input  1  carry-in, sampled on accept
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  sum, (op1 + op2 + carry_in) mod 2^WIDTH
carry_o  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset, asynchronous on rst_ni low:
  - State goes to IDLE; nibble counter = 0; carry register = 0; operand and sum registers = 0.
  - Outputs: ready_o=1, valid_o=0, sum_o=0, carry_o=0.
  - Assertion mid-operation aborts the operation; no partial result is ever presented.
- Number of nibbles: N = WIDTH/4. Counter width is max(1, $clog2(N)).
- FSM states and transitions:
  - IDLE: ready_o=1, valid_o=0. When valid_i && ready_o: latch op1_i, op2_i into shift registers; carry register <= carry_i; counter <= 0; go to RUN.
  - RUN: ready_o=0, valid_o=0. Each cycle:
    - Add the low nibbles of the operand registers plus the carry register in the 4-bit adder (combinational).
    - Shift the operand registers right by 4.
    - Shift the 4-bit sum into the top of the sum register (sum register shifts right by 4).
    - Carry register <= adder carry_o; counter increments.
    - On the cycle where counter == N-1, go to DONE.
  - DONE: ready_o=0, valid_o=1. sum_o and carry_o come from registers and are held stable while ready_i=0. When valid_o && ready_i, go to IDLE at the next edge; valid_o falls that edge.
- Latency: operands accepted at edge E; valid_o high after edge E+N (exactly N RUN cycles). For WIDTH=4, N=1.
- Throughput: one result every N+2 cycles minimum (IDLE accept, N RUN, DONE handshake).
- Output timing: sum_o and carry_o are valid only while valid_o=1. They keep their last value outside DONE and update only during RUN.
- Input handling: valid_i is ignored while ready_o=0. Operand inputs may change freely after the accept edge.
- Data paths are all unsigned modulo 2^WIDTH; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
- Defined: adds output port overflow_o (1 bit), registered and valid with valid_o.
  - Value is two's-complement overflow: (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]).
  - The operand MSBs are captured at accept, in a separate flop pair.
  - Reset value 0; held stable with sum_o.
- Not defined: port absent, no extra flops; all other behaviour identical.

Test Plan:
- WIDTH=32, op1=0xFFFFFFFF, op2=0x00000001, carry_i=0, ready_i=1 -> sum_o=0x00000000, carry_o=1; valid_o rises exactly 8 cycles after the accept edge and is high for 1 cycle.
- WIDTH=32, op1=0x12345678, op2=0x9ABCDEF0, carry_i=1 -> sum_o=0xACF13569, carry_o=0; ready_o low from accept until the result handshake.
- Back-pressure: result 0x0000000F+0x00000001=0x00000010 with ready_i=0 for 5 cycles -> valid_o, sum_o and carry_o stable all 5 cycles; valid_i pulses during this time are ignored; after ready_i=1, ready_o=1 on the next cycle.
- Reset mid-RUN: drop rst_ni at the 3rd RUN cycle -> immediately valid_o=0, ready_o=1, sum_o=0; a subsequent 0x1+0x1 gives 0x00000002 with normal latency.
- WIDTH=4 instance: op1=0xF, op2=0xF, carry_i=1 -> sum_o=0xF, carry_o=1, valid_o 1 cycle after accept.
- With NIBBLE_SERIAL_ADDER_OVERFLOW_EN, WIDTH=32: 0x7FFFFFFF+0x00000001 gives overflow_o=1; 0xFFFFFFFF+0x00000001 gives overflow_o=0, carry_o=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit Brent-Kung adder, one nibble per cycle, LSB first.
// Optional NIBBLE_SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow flag.

module brent_kung_adder_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);
  logic [3:0] g, p;
  logic       g0c, g10, g32, p32, g20, g30;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Carry-in folded into bit 0 so every prefix group starting at bit 0 is a pure generate.
  assign g0c = g[0] | (p[0] & carry_i);
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g30 = g32 | (p32 & g10);
  assign g20 = g[2] | (p[2] & g10);

  assign sum_o   = p ^ {g20, g10, g0c, carry_i};
  assign carry_o = g30;
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow_o,
`endif
  output logic             carry_o
);
  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [3:0]       nib_sum;
  logic             nib_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic             msb1_q, msb2_q;
`endif

  brent_kung_adder_4b u_adder (
    .a_i     (op1_q[3:0]),
    .b_i     (op2_q[3:0]),
    .carry_i (carry_q),
    .sum_o   (nib_sum),
    .carry_o (nib_carry)
  );

  // Control FSM plus operand/sum shift datapath; every output is a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      msb1_q     <= 1'b0;
      msb2_q     <= 1'b0;
      overflow_o <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op1_q   <= op1_i;
            op2_q   <= op2_i;
            carry_q <= carry_i;
            cnt_q   <= '0;
            ready_o <= 1'b0;
            state_q <= RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            msb1_q  <= op1_i[WIDTH-1];
            msb2_q  <= op2_i[WIDTH-1];
`endif
          end
        end
        RUN: begin
          op1_q   <= op1_q >> 4;
          op2_q   <= op2_q >> 4;
          sum_o   <= WIDTH'({nib_sum, sum_o} >> 4);
          carry_q <= nib_carry;
          carry_o <= nib_carry;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_q <= DONE;
            valid_o <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
            // Last nibble's top bit is the sum MSB.
            overflow_o <= (msb1_q == msb2_q) && (nib_sum[3] != msb1_q);
`endif
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
